// File: rtl/bus_pkg.sv
// Shared types and helpers for the shared bus controller: FSM state
// encoding, round-robin winner selection and response-line bit counting.
package bus_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_IDX_W   = 3;
    localparam int MAX_SLAVES  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_ADDR    = 3'd2,
        ST_STROBE  = 3'd3,
        ST_RELEASE = 3'd4
    } bus_state_e;

    // Returns the first requester at or after last+1 (mod n); holds last if none request.
    function automatic logic [MAX_IDX_W-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [MAX_IDX_W-1:0]   last,
        input int                     n
    );
        logic [MAX_IDX_W-1:0] pick;
        logic [MAX_IDX_W-1:0] cand;
        logic                 found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            cand = MAX_IDX_W'((int'(last) + k) % n);
            if (!found && (k <= n) && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Number of set bits; more than one slave answering is a collision.
    function automatic logic [3:0] onehot_count(input logic [MAX_SLAVES-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < MAX_SLAVES; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin selector: rotates the request vector past the
// previous winner and priority-encodes the first requester found.
module rr_priority_select
    import bus_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    logic [MAX_IDX_W-1:0] pick;

    // Winner search starts one past the last grant so no master is starved
    always_comb begin
        pick  = rr_pick(MAX_MASTERS'(req), MAX_IDX_W'(last), NUM_MASTERS);
        valid = |req;
        idx   = IDX_W'(pick);
    end

endmodule

// File: rtl/shared_bus_controller.sv
// Shared address/data bus sequencer: round-robin grant, address phase with
// timeout and collision detection, fixed-width data strobe, bus turnaround.
// Handshake: a master holds barq_i until its bagd_o bit drops; slaves answer
// an address phase (target_ready_o high) by raising exactly one slave_av_i bit.
module shared_bus_controller
    import bus_pkg::*;
#(
    parameter  int NUM_MASTERS     = 2,
    parameter  int NUM_SLAVES      = 2,
    parameter  int CLK_MAX_TIMEOUT = 10,
    parameter  int STROBE_LEN      = 1,
    localparam int IDX_W           = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] barq_i,
    output logic [NUM_MASTERS-1:0] bagd_o,
    output logic [IDX_W-1:0]       grant_idx_o,
    output logic                   target_ready_o,
    input  logic [NUM_SLAVES-1:0]  slave_av_i,
    output logic                   data_strobe_o,
    output logic                   done_o,
    output logic                   error_o
);

    localparam int TO_W = $clog2(CLK_MAX_TIMEOUT + 1);
    localparam int SB_W = $clog2(STROBE_LEN + 1);

    bus_state_e        state;
    logic [IDX_W-1:0]  last_ptr;
    logic [TO_W-1:0]   to_cnt;
    logic [SB_W-1:0]   sb_cnt;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [3:0]        av_count;
    logic              granted_req;

    rr_priority_select #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_select (
        .req   (barq_i),
        .last  (last_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign av_count    = onehot_count(MAX_SLAVES'(slave_av_i));
    assign granted_req = |(barq_i & bagd_o);

    // Transfer sequencer; every output is a register so the bus sees no glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            last_ptr       <= IDX_W'(NUM_MASTERS - 1);
            bagd_o         <= '0;
            grant_idx_o    <= '0;
            target_ready_o <= 1'b0;
            data_strobe_o  <= 1'b0;
            done_o         <= 1'b0;
            error_o        <= 1'b0;
            to_cnt         <= '0;
            sb_cnt         <= '0;
        end else begin
            done_o  <= 1'b0;
            error_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        bagd_o      <= NUM_MASTERS'(1) << pick_idx;
                        grant_idx_o <= pick_idx;
                        last_ptr    <= pick_idx;
                        state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!granted_req) begin
                        error_o <= 1'b1;
                        bagd_o  <= '0;
                        state   <= ST_RELEASE;
                    end else begin
                        target_ready_o <= 1'b1;
                        to_cnt         <= '0;
                        state          <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!granted_req || (av_count > 4'd1)) begin
                        // abort or collision: drop the bus without strobing
                        error_o        <= 1'b1;
                        bagd_o         <= '0;
                        target_ready_o <= 1'b0;
                        state          <= ST_RELEASE;
                    end else if (av_count == 4'd1) begin
                        // a response on the timeout edge still wins
                        data_strobe_o <= 1'b1;
                        sb_cnt        <= SB_W'(1);
                        state         <= ST_STROBE;
                    end else if (to_cnt == TO_W'(CLK_MAX_TIMEOUT - 1)) begin
                        error_o        <= 1'b1;
                        bagd_o         <= '0;
                        target_ready_o <= 1'b0;
                        state          <= ST_RELEASE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_STROBE: begin
                    // request drops here are ignored; the strobe always completes
                    if (sb_cnt == SB_W'(STROBE_LEN)) begin
                        done_o         <= 1'b1;
                        data_strobe_o  <= 1'b0;
                        bagd_o         <= '0;
                        target_ready_o <= 1'b0;
                        state          <= ST_RELEASE;
                    end else begin
                        sb_cnt <= sb_cnt + SB_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_controller.sv
// Bench for shared_bus_controller: transfer-level reference timeline feeding an
// expected-output queue, a per-cycle compare process, directed scenarios with
// hand-computed literals, and randomized transfers.
module tb_shared_bus_controller;

    localparam int NM  = 3;
    localparam int NS  = 2;
    localparam int TMO = 10;
    localparam int SL  = 3;
    localparam int IW  = $clog2(NM);
    localparam int EW  = NM + IW + 4;

    localparam int K_OK          = 0;
    localparam int K_TIMEOUT     = 1;
    localparam int K_COLLIDE     = 2;
    localparam int K_ABORT_GRANT = 3;
    localparam int K_ABORT_ADDR  = 4;
    localparam int K_STOP_STROBE = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NM-1:0] barq  = '0;
    logic [NS-1:0] av    = '0;
    logic [NM-1:0] bagd;
    logic [IW-1:0] gidx;
    logic          tr, sb, dn, er;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];

    // reference state: last winner and held mux select
    int last_w  = NM - 1;
    int cur_idx = 0;

    // observations collected by the compare process
    logic [NM-1:0] grant_log[$];
    int            gap_log[$];
    int grant_cyc = 0, tr_rise_cyc = 0, err_cyc = 0, done_cyc = 0;
    int strobe_run = 0, err_total = 0, done_total = 0, low_run = 0;
    logic tr_q = 1'b0, bagd_any_q = 1'b0;

    shared_bus_controller #(
        .NUM_MASTERS     (NM),
        .NUM_SLAVES      (NS),
        .CLK_MAX_TIMEOUT (TMO),
        .STROBE_LEN      (SL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .barq_i         (barq),
        .bagd_o         (bagd),
        .grant_idx_o    (gidx),
        .target_ready_o (tr),
        .slave_av_i     (av),
        .data_strobe_o  (sb),
        .done_o         (dn),
        .error_o        (er)
    );

    // clock
    always #5 clk = ~clk;

    // compare process: one expectation per posedge, checked on the following negedge
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        cyc++;
        a = {bagd, gidx, tr, sb, dn, er};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL cycle_outputs cyc=%0d got bagd=%b idx=%0d tr=%b sb=%b done=%b err=%b want bagd=%b idx=%0d tr=%b sb=%b done=%b err=%b",
                         cyc, bagd, gidx, tr, sb, dn, er,
                         e[EW-1 -: NM], e[IW+3:4], e[3], e[2], e[1], e[0]);
            end
        end
        if ((bagd != '0) && !bagd_any_q) begin
            grant_log.push_back(bagd);
            gap_log.push_back(low_run);
            grant_cyc  = cyc;
            strobe_run = 0;
        end
        if (bagd == '0) low_run++;
        else            low_run = 0;
        if (tr && !tr_q) tr_rise_cyc = cyc;
        if (sb) strobe_run++;
        if (er) begin err_cyc = cyc; err_total++; end
        if (dn) begin done_cyc = cyc; done_total++; end
        tr_q       = tr;
        bagd_any_q = |bagd;
    end

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    function automatic int rr_model(input logic [NM-1:0] m, input int last);
        int c;
        for (int k = 1; k <= NM; k++) begin
            c = (last + k) % NM;
            if (((m >> c) & NM'(1)) != '0) return c;
        end
        return last;
    endfunction

    function automatic logic [NS-1:0] rnd_av();
        return NS'($urandom_range(0, (1 << NS) - 1));
    endfunction

    function automatic logic [NS-1:0] one_slave();
        return NS'(1) << $urandom_range(0, NS - 1);
    endfunction

    function automatic logic [NM-1:0] rnd_mask0();
        return NM'($urandom_range(0, (1 << NM) - 1));
    endfunction

    // drive inputs for the next posedge and queue the outputs expected after it
    task automatic step(input logic [NM-1:0] b, input logic [NS-1:0] a,
                        input logic [NM-1:0] eg, input int ei,
                        input logic etr, input logic esb, input logic edn, input logic eer);
        @(negedge clk);
        #1;
        barq = b;
        av   = a;
        exp_q.push_back({eg, IW'(ei), etr, esb, edn, eer});
    endtask

    // one transfer starting in IDLE; r is the ADDR-phase edge (1..TMO) of the event
    task automatic xfer(input logic [NM-1:0] m, input int kind, input int r);
        int            w;
        logic [NM-1:0] g, md;
        w       = rr_model(m, last_w);
        last_w  = w;
        cur_idx = w;
        g       = NM'(1) << w;
        md      = m & ~g;
        step(m, rnd_av(), g, w, 1'b0, 1'b0, 1'b0, 1'b0);
        if (kind == K_ABORT_GRANT) begin
            step(md, rnd_av(), '0, w, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            step(m, rnd_av(), g, w, 1'b1, 1'b0, 1'b0, 1'b0);
            if (kind == K_TIMEOUT) begin
                for (int j = 1; j < TMO; j++) step(m, '0, g, w, 1'b1, 1'b0, 1'b0, 1'b0);
                step(m, '0, '0, w, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                for (int j = 1; j < r; j++) step(m, '0, g, w, 1'b1, 1'b0, 1'b0, 1'b0);
                case (kind)
                    K_COLLIDE:    step(m, '1, '0, w, 1'b0, 1'b0, 1'b0, 1'b1);
                    K_ABORT_ADDR: step(md, '0, '0, w, 1'b0, 1'b0, 1'b0, 1'b1);
                    default: begin
                        step(m, one_slave(), g, w, 1'b1, 1'b1, 1'b0, 1'b0);
                        if (kind == K_STOP_STROBE) return;
                        for (int s = 1; s < SL; s++)
                            step(rnd_mask0(), rnd_av(), g, w, 1'b1, 1'b1, 1'b0, 1'b0);
                        step(rnd_mask0(), rnd_av(), '0, w, 1'b0, 1'b0, 1'b1, 1'b0);
                    end
                endcase
            end
        end
        step(rnd_mask0(), rnd_av(), '0, w, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int e0, d0, n0, k, kind;
        int rr_exp[4];
        rr_exp = '{2, 1, 2, 1};

        // reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({bagd, gidx, tr, sb, dn, er}), 0);
        #1 rst_n = 1'b1;

        // single request, response on first ADDR edge
        e0 = err_total;
        d0 = done_total;
        xfer(3'b001, K_OK, 1);
        check("single_grant", int'(grant_log[$]), 1);
        check("single_grant_to_done", done_cyc - grant_cyc, 5);
        check("single_strobe_len", strobe_run, 3);
        check("single_no_error", err_total - e0, 0);
        check("single_done_count", done_total - d0, 1);

        // two masters requesting continuously alternate
        n0 = grant_log.size();
        repeat (4) xfer(3'b011, K_OK, $urandom_range(1, TMO));
        for (int i = 0; i < 4; i++) begin
            check("rr_order", int'(grant_log[n0 + i]), rr_exp[i]);
            check("rr_gap", gap_log[n0 + i], 2);
        end

        // no slave response
        e0 = err_total;
        xfer(3'b100, K_TIMEOUT, 0);
        check("timeout_latency", err_cyc - tr_rise_cyc, 10);
        check("timeout_no_strobe", strobe_run, 0);
        check("timeout_err_count", err_total - e0, 1);

        // two slaves answer at once
        e0 = err_total;
        xfer(3'b001, K_COLLIDE, 3);
        check("collision_no_strobe", strobe_run, 0);
        check("collision_err_count", err_total - e0, 1);

        // granted master withdraws during address phase
        e0 = err_total;
        d0 = done_total;
        xfer(3'b010, K_ABORT_ADDR, 2);
        check("abort_no_done", done_total - d0, 0);
        check("abort_err_count", err_total - e0, 1);

        // response on the timeout edge still wins
        d0 = done_total;
        xfer(3'b001, K_OK, TMO);
        check("late_response_done", done_total - d0, 1);

        // randomized traffic
        repeat (120) begin
            repeat ($urandom_range(0, 2)) step('0, rnd_av(), '0, cur_idx, 1'b0, 1'b0, 1'b0, 1'b0);
            k = $urandom_range(0, 9);
            kind = (k <= 4) ? K_OK :
                   (k == 5) ? K_TIMEOUT :
                   (k == 6) ? K_COLLIDE :
                   (k == 7) ? K_ABORT_GRANT :
                   (k == 8) ? K_ABORT_ADDR : K_OK;
            xfer(NM'($urandom_range(1, (1 << NM) - 1)), kind, $urandom_range(1, TMO));
        end

        // reset in the middle of a strobe
        xfer(3'b010, K_STOP_STROBE, 1);
        @(negedge clk);
        #2;
        check("strobe_before_reset", int'(sb), 1);
        rst_n = 1'b0;
        barq  = '0;
        av    = '0;
        #1;
        check("reset_mid_strobe", int'({bagd, gidx, tr, sb, dn, er}), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        last_w  = NM - 1;
        cur_idx = 0;
        xfer(3'b111, K_OK, 1);
        check("first_after_reset", int'(grant_log[$]), 1);

        @(negedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
